// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode and control-state encodings.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_ADC = 3'b101,
      OP_SHL = 3'b110,
      OP_SHR = 3'b111
   } op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } state_t;

endpackage

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe.
// Handshake: a beat transfers on a rising clock edge where valid and ready are
// both high; valid must not depend on ready, and the source holds its payload
// stable while valid is high and ready is low.
interface alu_pipe_if #(parameter int WIDTH = 8);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [2:0]       Sel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Result;
   logic             Carry;
   logic             Zero;
   logic             Overflow;
   logic             busy;

   modport master (
      output in_valid, A, B, Sel, out_ready,
      input  in_ready, out_valid, Result, Carry, Zero, Overflow, busy
   );

   modport slave (
      input  in_valid, A, B, Sel, out_ready,
      output in_ready, out_valid, Result, Carry, Zero, Overflow, busy
   );

endinterface

// File: rtl/alu_core.sv
// Combinational WIDTH-bit add/subtract/logic unit. Shifts are handled by the
// iterative shifter in alu_pipe, so they fall through to the default here.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  op_t              op,
   output logic [WIDTH-1:0] r,
   output logic             c,
   output logic             v
);

   localparam int MSB = WIDTH - 1;

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
   // Top bit of the widened difference is the unsigned borrow.
   assign diff = {1'b0, a} - {1'b0, b};

   // Select the operation result and its carry/overflow flags.
   always_comb begin
      r = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            r = sum[MSB:0];
            c = sum[WIDTH];
            v = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            r = diff[MSB:0];
            c = diff[WIDTH];
            v = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_AND: r = a & b;
         OP_OR:  r = a | b;
         OP_XOR: r = a ^ b;
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle arithmetic/logic ops, bit-serial shifts,
// registered result/flags and a stored carry for ADC chaining.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic   clk,
   input  logic   rst_n,
   alu_pipe_if.slave bus,
   output state_t dbg_state
);

   localparam int MSB     = WIDTH - 1;
   localparam int SHAMT_W = $clog2(WIDTH);

   state_t             state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q;
   logic [WIDTH-1:0]   sr_q;
   logic               sc_q;
   logic               dir_q;
   logic               c_flag;
   logic               out_valid_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q, zero_q, ovf_q;

   op_t                op;
   logic [SHAMT_W-1:0] n;
   logic               is_shift, accept, start_shift, out_free, last_shift;
   logic               load_direct, load_shift, load;
   logic [WIDTH-1:0]   sr_nxt, core_r, ld_r;
   logic               sc_nxt, core_c, core_v, ld_c, ld_v;

   assign op          = op_t'(bus.Sel);
   assign n           = bus.B[SHAMT_W-1:0];
   assign is_shift    = (op == OP_SHL) || (op == OP_SHR);
   assign out_free    = ~out_valid_q | bus.out_ready;
   assign bus.in_ready = rst_n & (state_q == IDLE) & out_free;
   assign accept      = bus.in_valid & bus.in_ready;
   assign start_shift = accept & is_shift & (n != '0);
   assign last_shift  = (state_q == SHIFT) && (cnt_q == SHAMT_W'(1));
   assign sr_nxt      = dir_q ? (sr_q >> 1) : (sr_q << 1);
   assign sc_nxt      = dir_q ? sr_q[0] : sr_q[MSB];
   assign load_direct = accept & ~start_shift;
   assign load_shift  = (last_shift | (state_q == LOAD)) & out_free;
   assign load        = load_direct | load_shift;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a   (bus.A),
      .b   (bus.B),
      .cin ((op == OP_ADC) ? c_flag : 1'b0),
      .op  (op),
      .r   (core_r),
      .c   (core_c),
      .v   (core_v)
   );

   // Pick what the output register captures: finished shift, zero-count shift, or core result.
   always_comb begin
      ld_r = core_r;
      ld_c = core_c;
      ld_v = core_v;
      if (load_shift) begin
         ld_r = (state_q == LOAD) ? sr_q : sr_nxt;
         ld_c = (state_q == LOAD) ? sc_q : sc_nxt;
         ld_v = 1'b0;
      end else if (is_shift) begin
         ld_r = bus.A;
         ld_c = 1'b0;
         ld_v = 1'b0;
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: LOAD only parks a finished shift if the output is still occupied.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_shift) state_d = SHIFT;
         SHIFT:   if (last_shift) state_d = out_free ? IDLE : LOAD;
         LOAD:    if (out_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Shifter: capture operand and count at accept, then one bit per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
         sc_q  <= 1'b0;
         dir_q <= 1'b0;
      end else if (start_shift) begin
         sr_q  <= bus.A;
         cnt_q <= n;
         sc_q  <= 1'b0;
         dir_q <= (op == OP_SHR);
      end else if (state_q == SHIFT) begin
         sr_q  <= sr_nxt;
         sc_q  <= sc_nxt;
         cnt_q <= cnt_q - SHAMT_W'(1);
      end
   end

   // Output register and stored carry; holds under backpressure, clears valid on drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         c_flag      <= 1'b0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         result_q    <= ld_r;
         carry_q     <= ld_c;
         zero_q      <= (ld_r == '0);
         ovf_q       <= ld_v;
         c_flag      <= ld_c;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.Result    = result_q;
   assign bus.Carry     = carry_q;
   assign bus.Zero      = zero_q;
   assign bus.Overflow  = ovf_q;
   assign bus.busy      = (state_q == SHIFT);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed scoreboard bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int W  = 8;
   localparam int EW = W + 3;   // {Result, Carry, Zero, Overflow}

   logic   clk;
   logic   rst_n;
   state_t dbg_state;

   alu_pipe_if #(.WIDTH(W)) bus ();

   alu_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   logic [EW-1:0] exp_q[$];
   int tests  = 0;
   int errors = 0;
   int pushed = 0;
   int popped = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic c,
                                         input logic z, input logic v);
      return {r, c, z, v};
   endfunction

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // driver: called at a falling edge, returns at the falling edge after the accept edge
   task automatic send(input logic [2:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic push, input logic [EW-1:0] exp);
      int waited = 0;
      bus.Sel = sel;
      bus.A = a;
      bus.B = b;
      bus.in_valid = 1'b1;
      if (push) begin
         exp_q.push_back(exp);
         pushed++;
      end
      #1;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         #1;
         waited++;
      end
      if (!bus.in_ready) begin
         tests++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for sel %0d", sel);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A = 8'hEE;
      bus.B = 8'hEE;
      @(negedge clk);
   endtask

   // measure latency from accept and busy cycles, starting at the falling edge after accept
   task automatic measure(input string name, input int exp_lat, input int exp_busy);
      int lat = 1;
      int bc  = bus.busy ? 1 : 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
         if (bus.busy) bc++;
      end
      check({name, "_latency"}, lat, exp_lat);
      check({name, "_busy_cycles"}, bc, exp_busy);
   endtask

   // scoreboard monitor: pop and compare on every output transfer
   always @(negedge clk) begin
      #1;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         tests++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: R=%h C=%b Z=%b V=%b with empty queue",
                     bus.Result, bus.Carry, bus.Zero, bus.Overflow);
         end else begin
            logic [EW-1:0] e;
            logic [EW-1:0] g;
            e = exp_q.pop_front();
            popped++;
            g = {bus.Result, bus.Carry, bus.Zero, bus.Overflow};
            if (g !== e)
               begin
                  errors++;
                  $display("FAIL result #%0d: got R=%h C=%b Z=%b V=%b expected R=%h C=%b Z=%b V=%b",
                           popped, g[EW-1:3], g[2], g[1], g[0], e[EW-1:3], e[2], e[1], e[0]);
               end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      bus.A = '0;
      bus.B = '0;
      bus.Sel = '0;

      // reset state
      #3;
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_result", bus.Result, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", bus.in_ready, 1);
      check("post_rst_state", dbg_state, IDLE);
      @(negedge clk);

      // arithmetic and logic
      send(3'b000, 8'h7F, 8'h01, 1'b1, pk(8'h80, 1'b0, 1'b0, 1'b1));
      measure("add", 1, 0);
      send(3'b001, 8'h02, 8'h03, 1'b1, pk(8'hFF, 1'b1, 1'b0, 1'b0));
      send(3'b101, 8'h10, 8'h20, 1'b1, pk(8'h31, 1'b0, 1'b0, 1'b0));

      // shifts (upper B bits ignored: 0xF3 -> count 3)
      send(3'b110, 8'h81, 8'hF3, 1'b1, pk(8'h08, 1'b0, 1'b0, 1'b0));
      measure("shl3", 4, 3);
      send(3'b111, 8'h81, 8'h01, 1'b1, pk(8'h40, 1'b1, 1'b0, 1'b0));
      measure("shr1", 2, 1);
      send(3'b110, 8'h81, 8'h00, 1'b1, pk(8'h81, 1'b0, 1'b0, 1'b0));
      measure("shl0", 1, 0);

      // logic ops, zero flag, carry chaining, signed overflow on subtract
      send(3'b100, 8'h5A, 8'h5A, 1'b1, pk(8'h00, 1'b0, 1'b1, 1'b0));
      send(3'b010, 8'hF0, 8'h3C, 1'b1, pk(8'h30, 1'b0, 1'b0, 1'b0));
      send(3'b011, 8'hF0, 8'h0F, 1'b1, pk(8'hFF, 1'b0, 1'b0, 1'b0));
      send(3'b000, 8'hFF, 8'h01, 1'b1, pk(8'h00, 1'b1, 1'b1, 1'b0));
      send(3'b101, 8'h00, 8'h00, 1'b1, pk(8'h01, 1'b0, 1'b0, 1'b0));
      send(3'b001, 8'h80, 8'h01, 1'b1, pk(8'h7F, 1'b0, 1'b0, 1'b1));

      // backpressure: result held, then same-edge drain and accept
      @(negedge clk);
      bus.out_ready = 1'b0;
      send(3'b000, 8'h11, 8'h22, 1'b1, pk(8'h33, 1'b0, 1'b0, 1'b0));
      for (int i = 0; i < 5; i++) begin
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_result", bus.Result, 8'h33);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      send(3'b001, 8'h05, 8'h05, 1'b1, pk(8'h00, 1'b0, 1'b1, 1'b0));
      check("bp_pop_count", popped, pushed - 1);

      // reset in the middle of a shift; c_flag is 1 beforehand
      send(3'b000, 8'hFF, 8'h02, 1'b1, pk(8'h01, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      send(3'b111, 8'hFF, 8'h07, 1'b0, '0);
      @(negedge clk);
      check("mid_shift_state", dbg_state, SHIFT);
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", bus.out_valid, 0);
      check("mrst_busy", bus.busy, 0);
      check("mrst_in_ready", bus.in_ready, 0);
      check("mrst_result", bus.Result, 0);
      check("mrst_carry", bus.Carry, 0);
      check("mrst_state", dbg_state, IDLE);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("mrst_release_in_ready", bus.in_ready, 1);
      @(negedge clk);
      send(3'b101, 8'h01, 8'h01, 1'b1, pk(8'h02, 1'b0, 1'b0, 1'b0));

      // final accounting
      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("all_results_seen", popped, pushed);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
